counter_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit tri-state bus among N_REQ counter instances.
- Drives the one-hot output enables of the counters, so at most one counter drives the bus in any cycle.
- Inserts turnaround (all-off) cycles between owners to prevent bus contention.
- Caps each ownership at MAX_HOLD cycles when others are waiting; sits between the counter bank and the bus consumer.

---
 rtl/counter_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_counter_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_bus_arbiter
// Description : Round-robin owner selection for one shared 8-bit tri-state
//               bus fed by a bank of counters. Produces one-hot-or-zero
//               output enables, inserts TA_CYCLES all-off turnaround cycles
//               between owners, and caps each ownership at MAX_HOLD cycles
//               while another requester is waiting.
// Optional    : define COUNTER_BUS_ARB_LOCK_EN to add the 'lock' input,
//               which lets the current owner keep the bus past MAX_HOLD.
// Ports       :
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous active-high reset
//   req       in   N_REQ  level requests, held high while bus is wanted
//   lock      in   1      (COUNTER_BUS_ARB_LOCK_EN only) owner keeps bus
//   oe        out  N_REQ  one-hot-or-zero tri-state enables
//   gnt_id    out  IDW    current owner index, valid while bus_valid=1
//   bus_valid out  1      high exactly when some oe bit is high
//   busy      out  1      high while owning or in turnaround
//   hold_cnt  out  8      cycles held by current owner (1-based), 0 if none
// Revision    : 1.0  initial release
// ============================================================================
module counter_bus_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int MAX_HOLD  = 8,
  parameter  int TA_CYCLES = 1,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
`ifdef COUNTER_BUS_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] oe,
  output logic [IDW-1:0]   gnt_id,
  output logic             bus_valid,
  output logic             busy,
  output logic [7:0]       hold_cnt
);

  localparam logic [IDW:0] N_REQ_W    = (IDW+1)'(N_REQ);
  localparam logic [7:0]   MAX_HOLD_W = 8'(MAX_HOLD);
  localparam logic [3:0]   TA_INIT    = 4'(TA_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [3:0]       ta_cnt;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   next_ptr;
  logic [IDW:0]     probe;
  logic [N_REQ-1:0] owner_mask;
  logic             owner_req;
  logic             others_req;
  logic             hold_at_max;
  logic             lock_active;

`ifdef COUNTER_BUS_ARB_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  // Round-robin search: probe indices rr_ptr, rr_ptr+1, ... wrapping at
  // N_REQ (which need not be a power of two), first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      probe = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (probe >= N_REQ_W) probe = probe - N_REQ_W;
      if (!win_found && req[probe[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = probe[IDW-1:0];
      end
    end
  end

  assign next_ptr    = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
  assign owner_mask  = N_REQ'(1) << gnt_id;
  assign owner_req   = |(req & owner_mask);
  assign others_req  = |(req & ~owner_mask);
  assign hold_at_max = (hold_cnt == MAX_HOLD_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      ta_cnt    <= '0;
      oe        <= '0;
      gnt_id    <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      case (state)
        S_OWN: begin
          // Owner dropping its request takes priority over the hold limit,
          // so a drop exactly at MAX_HOLD looks like a normal release.
          if (!owner_req || (hold_at_max && others_req && !lock_active)) begin
            state     <= S_TURN;
            oe        <= '0;
            bus_valid <= 1'b0;
            hold_cnt  <= 8'd0;
            ta_cnt    <= TA_INIT;
          end else if (hold_at_max) begin
            hold_cnt  <= 8'd1;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: begin
          // IDLE and the final TURN cycle share the same arbitration.
          if (state == S_TURN && ta_cnt != 4'd0) begin
            ta_cnt <= ta_cnt - 4'd1;
          end else if (win_found) begin
            state     <= S_OWN;
            oe        <= N_REQ'(1) << win_idx;
            gnt_id    <= win_idx;
            bus_valid <= 1'b1;
            busy      <= 1'b1;
            hold_cnt  <= 8'd1;
            rr_ptr    <= next_ptr;
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bus_arbiter
// Description : Directed and random stimulus for counter_bus_arbiter
//               (N_REQ=4, MAX_HOLD=3, TA_CYCLES=2) with a scoreboard of
//               expected per-cycle outputs plus bus-safety invariants.
// Revision    : 1.0  initial release
// ============================================================================
module tb_counter_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 3;
  localparam int TA = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
`ifdef COUNTER_BUS_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] oe;
  logic [1:0] gnt_id;
  logic       bus_valid;
  logic       busy;
  logic [7:0] hold_cnt;

  always #5 clk = ~clk;

  counter_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TA_CYCLES(TA)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
`ifdef COUNTER_BUS_ARB_LOCK_EN
    .lock      (lock),
`endif
    .oe        (oe),
    .gnt_id    (gnt_id),
    .bus_valid (bus_valid),
    .busy      (busy),
    .hold_cnt  (hold_cnt)
  );

  typedef struct {
    logic [3:0] oe;
    logic [7:0] hc;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] id = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) id = 2'(i);
    return id;
  endfunction

  // Drive one cycle of request and queue the outputs expected after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] e_oe,
                      input logic [7:0] e_hc, input logic e_busy);
    exp_t e;
    @(negedge clk);
    req    = r;
    e.oe   = e_oe;
    e.hc   = e_hc;
    e.busy = e_busy;
    sb.push_back(e);
  endtask

  task automatic turn_to_idle();
    for (int i = 0; i < TA; i++) step(4'b0000, 4'b0000, 8'd0, 1'b1);
    step(4'b0000, 4'b0000, 8'd0, 1'b0);
  endtask

  // Per-cycle checker: scoreboard pop plus invariants.
  int         zrun = 0;
  bit         seen = 0;
  logic [3:0] prev_oe = '0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      zrun    = 0;
      seen    = 0;
      prev_oe = '0;
    end else begin
      check("onehot", 32'($countones(oe) <= 1), 1);
      check("bus_valid_vs_oe", bus_valid, |oe);
      check("hold_vs_oe", ((hold_cnt != 0) == (oe != 0)) && (hold_cnt <= MH), 1);
      if (oe != 0) begin
        check("gnt_id_vs_oe", (oe === (4'd1 << gnt_id)), 1);
        check("turnaround_gap", (prev_oe == 0) ? (!seen || zrun >= TA) : (oe == prev_oe), 1);
        seen = 1;
        zrun = 0;
      end else begin
        zrun++;
      end
      prev_oe = oe;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("oe", oe, e.oe);
        check("hold_cnt", hold_cnt, e.hc);
        check("busy", busy, e.busy);
        check("bus_valid", bus_valid, |e.oe);
        if (e.oe != 0) check("gnt_id", gnt_id, oh2id(e.oe));
      end
    end
  end

  int ord[5];

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
`ifdef COUNTER_BUS_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_oe", oe, 4'b0000);
    check("rst_gnt_id", gnt_id, 2'd0);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hold_cnt", hold_cnt, 8'd0);
    reset = 1'b0;

    // Single requester: no turnaround while alone, hold_cnt wraps at MAX_HOLD.
    step(4'b0100, 4'b0100, 8'd1, 1'b1);
    for (int i = 1; i < 8; i++) step(4'b0100, 4'b0100, 8'((i % MH) + 1), 1'b1);
    turn_to_idle();
    step(4'b0000, 4'b0000, 8'd0, 1'b0);

    // All requesting: rotation starts after last owner (2), forced releases.
    ord = '{3, 0, 1, 2, 3};
    for (int k = 0; k < 5; k++) begin
      for (int h = 1; h <= MH; h++) step(4'b1111, 4'(1 << ord[k]), 8'(h), 1'b1);
      if (k < 4) for (int t = 0; t < TA; t++) step(4'b1111, 4'b0000, 8'd0, 1'b1);
    end
    turn_to_idle();

    // Owner 1 drops while 2 waits: exactly TA idle cycles then owner 2.
    step(4'b0010, 4'b0010, 8'd1, 1'b1);
    step(4'b0110, 4'b0010, 8'd2, 1'b1);
    step(4'b0100, 4'b0000, 8'd0, 1'b1);
    step(4'b0100, 4'b0000, 8'd0, 1'b1);
    step(4'b0100, 4'b0100, 8'd1, 1'b1);
    turn_to_idle();

    // Pointer wrap, forced release, then previous owner re-wins via rotation.
    step(4'b0001, 4'b0001, 8'd1, 1'b1);
    step(4'b0011, 4'b0001, 8'd2, 1'b1);
    step(4'b0011, 4'b0001, 8'd3, 1'b1);
    step(4'b0011, 4'b0000, 8'd0, 1'b1);
    step(4'b0011, 4'b0000, 8'd0, 1'b1);
    step(4'b0011, 4'b0010, 8'd1, 1'b1);
    step(4'b0001, 4'b0000, 8'd0, 1'b1);
    step(4'b0001, 4'b0000, 8'd0, 1'b1);
    step(4'b0001, 4'b0001, 8'd1, 1'b1);
    step(4'b0001, 4'b0001, 8'd2, 1'b1);
    step(4'b0001, 4'b0001, 8'd3, 1'b1);
    step(4'b0001, 4'b0001, 8'd1, 1'b1);
    step(4'b0001, 4'b0001, 8'd2, 1'b1);
    step(4'b0001, 4'b0001, 8'd3, 1'b1);
    // Owner drops exactly at MAX_HOLD while 1 is waiting.
    step(4'b0010, 4'b0000, 8'd0, 1'b1);
    step(4'b0010, 4'b0000, 8'd0, 1'b1);
    step(4'b0010, 4'b0010, 8'd1, 1'b1);
    turn_to_idle();

`ifdef COUNTER_BUS_ARB_LOCK_EN
    // Locked owner 0 keeps the bus past MAX_HOLD; unlock releases at next max.
    lock = 1'b1;
    step(4'b0001, 4'b0001, 8'd1, 1'b1);
    for (int i = 1; i <= 10; i++) step(4'b0011, 4'b0001, 8'((i % MH) + 1), 1'b1);
    lock = 1'b0;
    step(4'b0011, 4'b0001, 8'd3, 1'b1);
    step(4'b0011, 4'b0000, 8'd0, 1'b1);
    step(4'b0011, 4'b0000, 8'd0, 1'b1);
    step(4'b0011, 4'b0010, 8'd1, 1'b1);
    turn_to_idle();
`endif

    // Asynchronous reset mid-ownership tri-states the bus at once.
    step(4'b1111, 4'b0100, 8'd1, 1'b1);
    @(posedge clk);
    #3;
    req   = 4'b0000;
    reset = 1'b1;
    #1;
    check("async_rst_oe", oe, 4'b0000);
    check("async_rst_bus_valid", bus_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_hold_cnt", hold_cnt, 8'd0);
    check("async_rst_gnt_id", gnt_id, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 8'd0, 1'b0);
    // Round-robin pointer restarts at 0: requester 1 beats 3.
    step(4'b1010, 4'b0010, 8'd1, 1'b1);
    turn_to_idle();

    // Random traffic, checked by the invariants only.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req = 4'($urandom_range(0, 15));
`ifdef COUNTER_BUS_ARB_LOCK_EN
      lock = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk);
    req = 4'b0000;
`ifdef COUNTER_BUS_ARB_LOCK_EN
    lock = 1'b0;
`endif
    repeat (6) @(negedge clk);
    check("final_idle_busy", busy, 1'b0);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
